window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Raster-stream 3x3 neighbourhood generator that feeds the atmospheric-light estimator and the dark-channel stages.
//  Takes one 24-bit RGB pixel per accepted cycle and buffers the two previous image rows in line buffers.
//  Emits every fully-interior 3x3 window on output_pixel_1..9 with a qualifying valid strobe.
//  Marks the end of each frame with a one-cycle pulse.
// PARAMETERS
//  IMG_WIDTH   512  pixels per row; must be >= 3
//  IMG_HEIGHT  512  rows per frame; must be >= 3
// PORTS
//  clk             in   1   single clock; all logic on rising edge
//  rst             in   1   synchronous reset, active-high
//  i_valid         in   1   i_pixel is accepted this cycle (no backpressure)
//  i_pixel         in   24  {R[23:16],G[15:8],B[7:0]}, strict raster order
//  output_pixel_1  out  24  window (r-1,c-1), top-left
//  output_pixel_2  out  24  window (r-1,c)
//  output_pixel_3  out  24  window (r-1,c+1)
//  output_pixel_4  out  24  window (r,c-1)
//  output_pixel_5  out  24  window (r,c), centre
//  output_pixel_6  out  24  window (r,c+1)
//  output_pixel_7  out  24  window (r+1,c-1)
//  output_pixel_8  out  24  window (r+1,c)
//  output_pixel_9  out  24  window (r+1,c+1), bottom-right
//  o_valid         out  1   output_pixel_1..9 hold a complete window
//  o_frame_done    out  1   one-cycle pulse; last pixel of the frame was accepted
// BEHAVIOUR
//  Reset:
//   - all outputs 0; col/row counters 0; shift regs 0.
//   - Line-buffer RAM contents are not reset; they never reach a valid window.
//  Counters:
//   - col = $clog2(IMG_WIDTH) bits, row = $clog2(IMG_HEIGHT) bits.
//   - Both advance only on i_valid. col wraps at IMG_WIDTH-1 and increments row.
//   - row wraps at IMG_HEIGHT-1 to 0, so back-to-back frames need no idle cycle.
//  Line buffers:
//   - lb1 holds row r-1, lb0 holds row r-2; each is IMG_WIDTH x 24.
//   - Accepted pixel at (r,c): read lb0[c] and lb1[c], write lb0[c]<=lb1[c] and lb1[c]<=i_pixel, same cycle.
//  Window:
//   - 3 columns x 3 rows of registers.
//   - On accept, shift left by one column; new right column = {lb0[c], lb1[c], i_pixel} (top..bottom).
//   - No i_valid: all state and outputs hold, except o_valid and o_frame_done.
//  Validity:
//   - o_valid is registered: 1 in the cycle after accepting (r,c) with r>=2 and c>=2, else 0.
//   - The emitted window is centred on (r-1,c-1).
//   - Columns left over from the previous row are in the shift regs while c<2; they are never flagged valid.
//   - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2). No border replication.
//  Latency: 1 cycle from accepting pixel (r+1,c+1) to the window centred (r,c).
//  o_frame_done:
//   - Registered pulse the cycle after (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
//   - Coincides with the frame's last o_valid. Never high on consecutive cycles.
//  Mid-operation reset: the next accepted pixel is (0,0). No window mixes pre- and post-reset rows.
//  Frame wrap: rows 0..1 of the new frame produce no windows.
// TESTING (pixel value = {8'h0, row[7:0], col[7:0]} for traceability)
//  1. W=H=4, continuous 16 pixels -> exactly 4 o_valid.
//     First one is in the cycle after (2,2): pixel_1=0x000000, pixel_5=0x000101, pixel_9=0x000202.
//  2. W=H=4, i_valid toggled 1/0 -> same 4 windows in the same order; o_valid never high 2 cycles running.
//  3. W=H=4, two back-to-back frames -> o_frame_done high the cycle after each (3,3).
//     Frame-2 first window has pixel_1=0x000000 of frame 2 (use distinct R byte per frame to check).
//  4. rst after 6 pixels of a 4x4 frame -> o_valid=0, o_frame_done=0 next cycle.
//     A fresh 16-pixel frame yields exactly 4 correct windows.
//  5. W=H=3 -> one window, centre 0x000101, o_valid and o_frame_done high together.
//  6. Default 512x512 random frame -> 260100 windows; each window matches a software 3x3 model.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 neighbourhood generator: two line buffers plus a 3x3 register window,
// emitting every fully-interior window one cycle after its bottom-right pixel is accepted.
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [23:0] i_pixel,
  output logic [23:0] output_pixel_1,
  output logic [23:0] output_pixel_2,
  output logic [23:0] output_pixel_3,
  output logic [23:0] output_pixel_4,
  output logic [23:0] output_pixel_5,
  output logic [23:0] output_pixel_6,
  output logic [23:0] output_pixel_7,
  output logic [23:0] output_pixel_8,
  output logic [23:0] output_pixel_9,
  output logic        o_valid,
  output logic        o_frame_done
);

  localparam int unsigned PW = 24;
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic          valid_nxt, done_nxt;

  // lb1 holds row r-1, lb0 holds row r-2; contents are never reset
  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] lb0_rd, lb1_rd;

  // win[row][col], row 0 = top, col 2 = newest column
  logic [PW-1:0] win [3][3];

  assign lb0_rd = lb0[col];
  assign lb1_rd = lb1[col];

  // Raster position advance and output qualification for the pixel being accepted
  always_comb begin
    col_nxt   = col;
    row_nxt   = row;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (i_valid) begin
      valid_nxt = (row >= ROW_FIRST) && (col >= COL_FIRST);
      done_nxt  = (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      col          <= col_nxt;
      row          <= row_nxt;
      o_valid      <= valid_nxt;
      o_frame_done <= done_nxt;
      if (i_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= i_pixel;
      end
    end
  end

  // Line buffers shift one row down per accepted pixel (read-before-write)
  always_ff @(posedge clk) begin
    if (i_valid) begin
      lb0[col] <= lb1_rd;
      lb1[col] <= i_pixel;
    end
  end

  assign output_pixel_1 = win[0][0];
  assign output_pixel_2 = win[0][1];
  assign output_pixel_3 = win[0][2];
  assign output_pixel_4 = win[1][0];
  assign output_pixel_5 = win[1][1];
  assign output_pixel_6 = win[1][2];
  assign output_pixel_7 = win[2][0];
  assign output_pixel_8 = win[2][1];
  assign output_pixel_9 = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: 4x4 and 3x3 instances, window contents,
// validity spacing, frame-done timing, back-to-back frames and mid-frame reset.
module tb_window_3x3_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              v4, v3;
  logic [23:0]       px4, px3;
  logic [8:0][23:0]  o4, o3;
  logic              ov4, fd4, ov3, fd3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(v4), .i_pixel(px4),
    .output_pixel_1(o4[0]), .output_pixel_2(o4[1]), .output_pixel_3(o4[2]),
    .output_pixel_4(o4[3]), .output_pixel_5(o4[4]), .output_pixel_6(o4[5]),
    .output_pixel_7(o4[6]), .output_pixel_8(o4[7]), .output_pixel_9(o4[8]),
    .o_valid(ov4), .o_frame_done(fd4)
  );

  window_3x3_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk(clk), .rst(rst), .i_valid(v3), .i_pixel(px3),
    .output_pixel_1(o3[0]), .output_pixel_2(o3[1]), .output_pixel_3(o3[2]),
    .output_pixel_4(o3[3]), .output_pixel_5(o3[4]), .output_pixel_6(o3[5]),
    .output_pixel_7(o3[6]), .output_pixel_8(o3[7]), .output_pixel_9(o3[8]),
    .o_valid(ov3), .o_frame_done(fd3)
  );

  typedef struct packed {
    logic [8:0][23:0] p;
    logic             fd;
    int               cyc;
  } ent_t;

  typedef struct {
    int          cr;
    int          cc;
    logic [23:0] p1;
    logic [23:0] p5;
    logic [23:0] p9;
  } vec_t;

  ent_t log4[$];
  int   fd4_cyc[$];
  int   dbl4 = 0;
  int   nv3 = 0;
  logic prev4 = 1'b0;

  int ntests = 0;
  int nfail  = 0;
  vec_t tbl [4];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    ent_t e;
    if (ov4) begin
      e.p   = o4;
      e.fd  = fd4;
      e.cyc = cyc;
      log4.push_back(e);
    end
    if (fd4) fd4_cyc.push_back(cyc);
    if (ov4 && prev4) dbl4++;
    prev4 = ov4;
    if (ov3) nv3++;
  end

  function automatic logic [23:0] pix(input logic [7:0] tag, input int r, input int c);
    return {tag, 8'(r), 8'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v4 = 1'b0;
      v3 = 1'b0;
    end
  endtask

  task automatic send4(input logic [7:0] tag, input bit gap, output int last);
    last = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        v4   = 1'b1;
        px4  = pix(tag, r, c);
        last = cyc;
        if (gap) begin
          @(negedge clk);
          v4 = 1'b0;
        end
      end
    end
  endtask

  // Compare four logged windows starting at base against the table and pixel model
  task automatic check_frame(input string name, input logic [7:0] tag, input int base,
                             input int last);
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      if (base + i >= log4.size()) begin
        chk($sformatf("%s win%0d missing", name, i), 32'(log4.size()), 32'(base + 4));
      end else begin
        e = log4[base + i];
        chk($sformatf("%s win%0d p1", name, i), 32'(e.p[0]), 32'({tag, tbl[i].p1[15:0]}));
        chk($sformatf("%s win%0d p5", name, i), 32'(e.p[4]), 32'({tag, tbl[i].p5[15:0]}));
        chk($sformatf("%s win%0d p9", name, i), 32'(e.p[8]), 32'({tag, tbl[i].p9[15:0]}));
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("%s win%0d px%0d", name, i, k + 1), 32'(e.p[k]),
              32'(pix(tag, tbl[i].cr - 1 + k / 3, tbl[i].cc - 1 + k % 3)));
        end
        chk($sformatf("%s win%0d fd", name, i), 32'(e.fd), 32'(i == 3));
        if (i == 3) chk($sformatf("%s last win cycle", name), 32'(e.cyc), 32'(last + 1));
      end
    end
  endtask

  initial begin
    int la, lb;

    tbl[0] = '{cr: 1, cc: 1, p1: 24'h000000, p5: 24'h000101, p9: 24'h000202};
    tbl[1] = '{cr: 1, cc: 2, p1: 24'h000001, p5: 24'h000102, p9: 24'h000203};
    tbl[2] = '{cr: 2, cc: 1, p1: 24'h000100, p5: 24'h000201, p9: 24'h000302};
    tbl[3] = '{cr: 2, cc: 2, p1: 24'h000101, p5: 24'h000202, p9: 24'h000303};

    rst = 1'b1; v4 = 1'b0; v3 = 1'b0; px4 = '0; px3 = '0;
    idle(3);
    chk("reset o_valid", 32'(ov4), 32'd0);
    chk("reset o_frame_done", 32'(fd4), 32'd0);
    chk("reset pixel_1", 32'(o4[0]), 32'd0);
    chk("reset pixel_5", 32'(o4[4]), 32'd0);
    chk("reset 3x3 o_valid", 32'(ov3), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous frame
    log4.delete(); fd4_cyc.delete();
    send4(8'h00, 1'b0, la);
    idle(3);
    chk("t1 window count", 32'(log4.size()), 32'd4);
    check_frame("t1", 8'h00, 0, la);
    chk("t1 fd count", 32'(fd4_cyc.size()), 32'd1);

    // Gapped frame; window holds across idle cycles
    log4.delete(); fd4_cyc.delete(); dbl4 = 0;
    send4(8'h11, 1'b1, la);
    idle(3);
    chk("t2 window count", 32'(log4.size()), 32'd4);
    check_frame("t2", 8'h11, 0, la);
    chk("t2 back-to-back valids", 32'(dbl4), 32'd0);
    chk("t2 hold pixel_5", 32'(o4[4]), 32'(pix(8'h11, 2, 2)));
    chk("t2 hold o_valid low", 32'(ov4), 32'd0);

    // Two frames with no idle cycle between
    log4.delete(); fd4_cyc.delete();
    send4(8'h21, 1'b0, la);
    send4(8'h22, 1'b0, lb);
    idle(3);
    chk("t3 window count", 32'(log4.size()), 32'd8);
    check_frame("t3f1", 8'h21, 0, la);
    check_frame("t3f2", 8'h22, 4, lb);
    chk("t3 fd count", 32'(fd4_cyc.size()), 32'd2);
    if (fd4_cyc.size() == 2) begin
      chk("t3 fd1 cycle", 32'(fd4_cyc[0]), 32'(la + 1));
      chk("t3 fd2 cycle", 32'(fd4_cyc[1]), 32'(lb + 1));
    end

    // Reset after six pixels, then a fresh frame
    log4.delete(); fd4_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v4  = 1'b1;
      px4 = pix(8'h55, i / 4, i % 4);
    end
    @(negedge clk);
    v4  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4 o_valid after rst", 32'(ov4), 32'd0);
    chk("t4 o_frame_done after rst", 32'(fd4), 32'd0);
    chk("t4 pixel_5 after rst", 32'(o4[4]), 32'd0);
    chk("t4 no partial windows", 32'(log4.size()), 32'd0);
    send4(8'h66, 1'b0, la);
    idle(3);
    chk("t4 window count", 32'(log4.size()), 32'd4);
    check_frame("t4", 8'h66, 0, la);
    chk("t4 fd count", 32'(fd4_cyc.size()), 32'd1);

    // 3x3 image: single window with frame done
    nv3 = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      v3  = 1'b1;
      px3 = pix(8'h00, i / 3, i % 3);
    end
    @(negedge clk);
    v3 = 1'b0;
    chk("t5 o_valid", 32'(ov3), 32'd1);
    chk("t5 o_frame_done", 32'(fd3), 32'd1);
    chk("t5 pixel_1", 32'(o3[0]), 32'h000000);
    chk("t5 pixel_5", 32'(o3[4]), 32'h000101);
    chk("t5 pixel_9", 32'(o3[8]), 32'h000202);
    idle(3);
    chk("t5 window count", 32'(nv3), 32'd1);
    chk("t5 fd clears", 32'(fd3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
